sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Parametrised N-channel arbiter that merges memory requests from the Processor, GraphicSystem and SD-card loader onto the single request port of the SDRAM controller. It sits between the clients and the controller inside Top. It keeps one transaction outstanding, selects clients round-robin, and captures the winning request so the client is released at grant. Optionally, channel 0 (graphics scanout) gets bounded strict priority.

## Interface
- CHANNELS, 3, number of client channels (2..8)
- ADDR_WIDTH, 24, word address width
- DATA_WIDTH, 32, data width; must be a multiple of 8
- MAX_WAIT, 4, with priority enabled: consecutive channel-0 grants allowed while another channel waits (1..15)
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ch_valid  in  CHANNELS  per-channel request valid
- ch_write  in  CHANNELS  1 = write, 0 = read
- ch_addr  in  CHANNELS*ADDR_WIDTH  packed addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wdata  in  CHANNELS*DATA_WIDTH  packed write data
- ch_mask  in  CHANNELS*DATA_WIDTH/8  packed byte enables, active-high
- ch_ready  out  CHANNELS  one-hot grant pulse; request captured this cycle
- ch_done  out  CHANNELS  one-hot completion pulse to the owning channel
- ch_rdata  out  DATA_WIDTH  read data, valid with ch_done; shared by all channels
- mem_valid  out  1  request to controller
- mem_ready  in  1  controller accepts the request
- mem_write, mem_addr, mem_wdata, mem_mask  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  captured request
- mem_done  in  1  controller completion pulse (read or write)
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_done

## Operation
- FSM states:
  - IDLE: if any ch_valid is set, grant one channel. Assert ch_ready[g] combinationally, capture its fields and owner index at the clock edge, then go to ISSUE.
  - ISSUE: hold mem_valid and the fields until mem_valid&&mem_ready, then go to WAIT.
  - WAIT: on mem_done, route it to ch_done[owner], then go to IDLE.
- Round-robin: search starts at (last_grant+1) mod CHANNELS. last_grant updates on every grant and resets to CHANNELS-1, so channel 0 wins first.
- Captured fields are registered. Client inputs may change freely once ch_ready has pulsed.
- A client that drops ch_valid before it is granted is never granted.
- ch_rdata = mem_rdata (combinational pass-through). ch_done[i] = mem_done && state==WAIT && owner==i.
- mem_done outside WAIT is ignored and produces no ch_done.
- A mem_ready that arrives in the same cycle the FSM enters ISSUE counts only from the ISSUE cycle onward.
- Reset behaviour:
  - State returns to IDLE. mem_valid, ch_ready and ch_done go to 0. Captured fields and the starvation counter reset to 0. last_grant resets to CHANNELS-1.
  - Reset mid-transaction abandons the transaction, and a later mem_done is ignored.

## Timing
- Request at cycle n in IDLE: ch_ready at n, mem_valid at n+1.
- Minimum turnaround: IDLE 1 cycle + ISSUE ≥1 + WAIT ≥1, so back-to-back grants are at least 3 cycles apart.
- ch_done coincides with mem_done; the next grant can occur the following cycle.
- At most one ch_ready bit and one ch_done bit is high in any cycle.

## Configuration
- SDRAM_ARB_PRIORITY_EN defined:
  - In IDLE, channel 0 wins whenever it is valid, unless the starvation counter equals MAX_WAIT.
  - The counter increments on each channel-0 grant made while any other channel is valid.
  - The counter clears to 0 on any non-zero-channel grant, and on a channel-0 grant made with no other channel valid.
  - When the counter equals MAX_WAIT, the round-robin search excludes channel 0 for that grant.
- SDRAM_ARB_PRIORITY_EN undefined: pure round-robin. The counter logic is not built.

## Test plan
- Single read: ch_valid=001, addr0=0x000100; controller ready immediately, mem_done 5 cycles later with rdata 0xDEADBEEF -> ch_ready=001 at n, mem_valid at n+1 with addr 0x000100, ch_done=001 with ch_rdata=0xDEADBEEF.
- Fairness, macro off: all three channels continuously valid for 9 grants -> grant order 0,1,2,0,1,2,0,1,2.
- Priority, macro on, MAX_WAIT=4: channels 0 and 2 continuously valid -> grant order 0,0,0,0,2,0,0,0,0,2.
- Backpressure: mem_ready held low for 10 cycles -> mem_valid and mem_addr stable for all 10 cycles, no further ch_ready, and a single accept.
- Masked write: channel 1 writes 0x11223344 with mask 0110 -> mem_wdata=0x11223344, mem_mask=0110, mem_write=1, then ch_done=010.
- Reset in WAIT, then a stray mem_done -> all outputs 0, no ch_done, and the next request is granted from channel 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin merge of CHANNELS client request ports onto one SDRAM controller port
// Ports: clk/reset (sync, active-high); ch_valid/ch_write/ch_addr/ch_wdata/ch_mask client requests (packed per channel);
// ch_ready one-hot grant, ch_done one-hot completion, ch_rdata shared read data;
// mem_valid/mem_ready handshake, mem_write/mem_addr/mem_wdata/mem_mask captured request, mem_done/mem_rdata completion.
// Optional bounded strict priority for channel 0 when SDRAM_ARB_PRIORITY_EN is defined.
module sdram_port_arbiter #(
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              ch_valid,
  input  logic [CHANNELS-1:0]              ch_write,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_wdata,
  input  logic [CHANNELS*DATA_WIDTH/8-1:0] ch_mask,
  output logic [CHANNELS-1:0]              ch_ready,
  output logic [CHANNELS-1:0]              ch_done,
  output logic [DATA_WIDTH-1:0]            ch_rdata,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [DATA_WIDTH/8-1:0]          mem_mask,
  input  logic                             mem_done,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);
  localparam int IW = $clog2(CHANNELS);
  localparam int MW = DATA_WIDTH / 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (CHANNELS < 2 || CHANNELS > 8 || DATA_WIDTH % 8 != 0 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_params
    $error("sdram_port_arbiter: illegal parameter combination");
  end

  logic [1:0]            r_state;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_owner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MW-1:0]         r_mask;
  logic [CHANNELS-1:0]   w_req;
  logic                  w_found;
  logic [IW-1:0]         w_idx;
  logic                  w_grant;
`ifdef SDRAM_ARB_PRIORITY_EN
  logic [3:0]            r_cnt;
  logic                  w_others;
  logic                  w_excl;
  assign w_others = |ch_valid[CHANNELS-1:1];
  // Channel 0 is only locked out when someone else is actually waiting, so a lone channel 0 never stalls.
  assign w_excl   = (r_cnt == 4'(MAX_WAIT)) && w_others;
`endif

  always_comb begin
    int j;
    w_req   = ch_valid;
`ifdef SDRAM_ARB_PRIORITY_EN
    if (w_excl) w_req[0] = 1'b0;
`endif
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      j = (int'(r_last) + k) % CHANNELS;
      if (!w_found && w_req[j]) begin
        w_found = 1'b1;
        w_idx   = IW'(j);
      end
    end
`ifdef SDRAM_ARB_PRIORITY_EN
    if (ch_valid[0] && !w_excl) begin
      w_found = 1'b1;
      w_idx   = '0;
    end
`endif
  end

  assign w_grant   = !reset && r_state == S_IDLE && w_found;
  assign ch_ready  = w_grant ? CHANNELS'(1) << w_idx : '0;
  assign ch_done   = (!reset && r_state == S_WAIT && mem_done) ? CHANNELS'(1) << r_owner : '0;
  assign ch_rdata  = mem_rdata;
  assign mem_valid = !reset && r_state == S_ISSUE;
  assign mem_write = r_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask  = r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= IW'(CHANNELS - 1);
      r_owner <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
`ifdef SDRAM_ARB_PRIORITY_EN
      r_cnt   <= '0;
`endif
    end else if (w_grant) begin
      r_state <= S_ISSUE;
      r_last  <= w_idx;
      r_owner <= w_idx;
      r_write <= ch_write[w_idx];
      r_addr  <= ch_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata <= ch_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
      r_mask  <= ch_mask[w_idx*MW +: MW];
`ifdef SDRAM_ARB_PRIORITY_EN
      r_cnt   <= (w_idx == '0 && w_others) ? r_cnt + 4'd1 : 4'd0;
`endif
    end else if (r_state == S_ISSUE && mem_ready) begin
      r_state <= S_WAIT;
    end else if (r_state == S_WAIT && mem_done) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scoreboard bench for sdram_port_arbiter (CHANNELS=3, 24-bit addr, 32-bit data)
module tb_sdram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ch_valid, ch_write, ch_ready, ch_done;
  logic [71:0] ch_addr;
  logic [95:0] ch_wdata;
  logic [11:0] ch_mask;
  logic [31:0] ch_rdata, mem_wdata, mem_rdata;
  logic        mem_valid, mem_ready, mem_write, mem_done;
  logic [23:0] mem_addr;
  logic [3:0]  mem_mask;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [1:0]  ch;
    logic        w;
    logic [23:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  sdram_port_arbiter #(.CHANNELS(3), .ADDR_WIDTH(24), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .ch_valid(ch_valid), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_mask(ch_mask),
    .ch_ready(ch_ready), .ch_done(ch_done), .ch_rdata(ch_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int c);
    exp_t e;
    e.ch = 2'(c);
    e.w  = ch_write[c];
    e.a  = ch_addr[c*24 +: 24];
    e.d  = ch_wdata[c*32 +: 32];
    e.m  = ch_mask[c*4 +: 4];
    q.push_back(e);
  endtask
  task automatic serve(input logic [2:0] nv, input int rlat, input int dlat, input logic [31:0] rd);
    exp_t e;
    int n;
    n = 0;
    while (ch_ready == 3'b000 && n < 20) begin
      cyc();
      n++;
    end
    e = q.pop_front();
    chk("grant", ch_ready, (3'b001 << e.ch));
    cyc();
    ch_valid = nv;
    if (nv == 3'b000) begin
      ch_write = ~ch_write;
      ch_addr  = ~ch_addr;
      ch_wdata = ~ch_wdata;
      ch_mask  = ~ch_mask;
    end
    #1;
    repeat (rlat) begin
      total += 3;
      if (mem_valid !== 1'b1) begin bad++; $error("FAIL hold_valid observed=%0h", mem_valid); end
      if (mem_addr !== e.a) begin bad++; $error("FAIL hold_addr observed=%0h expected=%0h", mem_addr, e.a); end
      if (ch_ready !== 3'b000) begin bad++; $error("FAIL hold_no_grant observed=%0h", ch_ready); end
      cyc();
    end
    chk("mem_valid", mem_valid, 1'b1);
    chk("mem_write", mem_write, e.w);
    chk("mem_addr", mem_addr, e.a);
    chk("mem_wdata", mem_wdata, e.d);
    chk("mem_mask", mem_mask, e.m);
    chk("issue_no_grant", ch_ready, 3'b000);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("single_accept", mem_valid, 1'b0);
    repeat (dlat) begin
      total++;
      if (ch_done !== 3'b000) begin bad++; $error("FAIL early_done observed=%0h", ch_done); end
      cyc();
    end
    mem_rdata = rd;
    mem_done  = 1'b1;
    #1;
    chk("ch_done", ch_done, (3'b001 << e.ch));
    chk("ch_rdata", ch_rdata, rd);
    cyc();
    mem_done  = 1'b0;
    mem_rdata = '0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; ch_valid = 3'b111; ch_write = '0; ch_addr = '0; ch_wdata = '0; ch_mask = '0;
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = '0;
    repeat (3) cyc();
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_ch_ready", ch_ready, 3'b000);
    chk("rst_ch_done", ch_done, 3'b000);
    ch_valid = '0; mem_done = 1'b0; reset = 1'b0;
    cyc();
    chk("rst_mem_addr", mem_addr, 24'h0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_mask", mem_mask, 4'h0);
    chk("idle_no_grant", ch_ready, 3'b000);
    ch_addr[23:0] = 24'h000100; ch_valid = 3'b001; push(0); #1;
    serve(3'b000, 0, 5, 32'hDEADBEEF);
    mem_done = 1'b1; mem_rdata = 32'h55AA55AA; #1;
    chk("stray_done_idle", ch_done, 3'b000);
    cyc();
    mem_done = 1'b0;
    chk("stray_no_issue", mem_valid, 1'b0);
    ch_write = 3'b010; ch_addr = '0; ch_addr[47:24] = 24'h0ABCDE; ch_wdata = '0; ch_wdata[63:32] = 32'h11223344;
    ch_mask = '0; ch_mask[7:4] = 4'b0110; ch_valid = 3'b010; push(1); #1;
    serve(3'b000, 0, 2, 32'h0BADF00D);
    ch_write = '0; ch_addr = '0; ch_wdata = '0; ch_mask = '0;
    ch_addr[71:48] = 24'h000200; ch_addr[23:0] = 24'h000100; ch_valid = 3'b100; push(2); #1;
    serve(3'b101, 10, 1, 32'hCAFEF00D);
    push(0);
    serve(3'b000, 0, 1, 32'h12345678);
    ch_write = '0; ch_addr = '0; ch_wdata = '0; ch_mask = '0;
    ch_addr[47:24] = 24'h000333; ch_valid = 3'b010; #1;
    chk("rw_grant", ch_ready, 3'b010);
    cyc();
    ch_valid = '0; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("rw_in_wait", mem_valid, 1'b0);
    reset = 1'b1; ch_valid = 3'b111; #1;
    chk("rw_rst_ready", ch_ready, 3'b000);
    chk("rw_rst_valid", mem_valid, 1'b0);
    cyc();
    reset = 1'b0; ch_valid = '0; #1;
    chk("rw_addr_cleared", mem_addr, 24'h0);
    mem_done = 1'b1; #1;
    chk("rw_stray_done", ch_done, 3'b000);
    cyc();
    mem_done = 1'b0;
    chk("rw_idle", mem_valid, 1'b0);
    ch_addr = {24'h0000C2, 24'h0000C1, 24'h0000C0};
`ifndef SDRAM_ARB_PRIORITY_EN
    ch_valid = 3'b111; #1;
    for (int i = 0; i < 9; i++) push(i % 3);
    for (int i = 0; i < 9; i++) serve(3'b111, i % 2, 1, 32'(i));
`else
    begin
      int ord[10];
      ord = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
      ch_valid = 3'b101; #1;
      for (int i = 0; i < 10; i++) push(ord[i]);
      for (int i = 0; i < 10; i++) serve(3'b101, i % 2, 1, 32'(i));
    end
`endif
    ch_valid = '0; #1;
    chk("final_no_grant", ch_ready, 3'b000);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
